// File: rtl/spi_cmd_ctrl.sv
// SPI command decoder: a command byte sets the address and direction.
// Following bytes become register-bank writes, or dummy bytes that trigger reads.
module spi_cmd_ctrl #(
    parameter int TIMEOUT = 16
) (
    input  logic       in_clk,
    input  logic       in_rst,
    input  logic       in_cs_n,
    input  logic       in_rx_valid,
    input  logic [7:0] in_rx_byte,
    output logic [7:0] o_tx_byte,
    output logic       o_tx_valid,
    output logic [6:0] o_reg_addr,
    output logic [7:0] o_reg_wdata,
    output logic       o_reg_we,
    output logic       o_reg_re,
    input  logic [7:0] in_reg_rdata,
    input  logic       in_reg_ack,
    input  logic       in_err_clr,
    output logic       o_busy,
    output logic       o_err,
    output logic [7:0] o_frame_cnt,
    output logic [2:0] dbg_state
);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        CMD     = 3'd1,
        WR_DATA = 3'd2,
        WR_REQ  = 3'd3,
        RD_REQ  = 3'd4,
        RD_WAIT = 3'd5
    } state_t;

    localparam logic [7:0] TMR_LAST = 8'(TIMEOUT - 1);

    state_t     state, state_d;
    logic       cs_prev;
    logic [6:0] addr, addr_d;
    logic [7:0] wdata, wdata_d;
    logic [7:0] tx_byte, tx_byte_d;
    logic       tx_valid, tx_valid_d;
    logic       err, err_d, err_event;
    logic [7:0] frame_cnt, frame_cnt_d;
    logic [7:0] tmr, tmr_d;

    // Register handshake: o_reg_we/o_reg_re is a level request held with stable
    // address/data until the single-cycle in_reg_ack, then drops the next cycle.
    always_ff @(posedge in_clk) begin
        if (in_rst) begin
            state     <= IDLE;
            cs_prev   <= 1'b0;
            addr      <= 7'h00;
            wdata     <= 8'h00;
            tx_byte   <= 8'h00;
            tx_valid  <= 1'b0;
            err       <= 1'b0;
            frame_cnt <= 8'h00;
            tmr       <= 8'h00;
        end else begin
            state     <= state_d;
            cs_prev   <= in_cs_n;
            addr      <= addr_d;
            wdata     <= wdata_d;
            tx_byte   <= tx_byte_d;
            tx_valid  <= tx_valid_d;
            err       <= err_d;
            frame_cnt <= frame_cnt_d;
            tmr       <= tmr_d;
        end
    end

    always_comb begin
        state_d     = state;
        addr_d      = addr;
        wdata_d     = wdata;
        tx_byte_d   = tx_byte;
        tx_valid_d  = 1'b0;
        frame_cnt_d = frame_cnt;
        tmr_d       = tmr;
        err_event   = 1'b0;

        // Chip-select release overrides everything, including a same-cycle ack.
        if (state != IDLE && in_cs_n) begin
            state_d     = IDLE;
            frame_cnt_d = frame_cnt + 8'd1;
        end else begin
            case (state)
                IDLE: begin
                    if (cs_prev && !in_cs_n) state_d = CMD;
                end
                CMD: begin
                    if (in_rx_valid) begin
                        addr_d  = in_rx_byte[6:0];
                        tmr_d   = 8'h00;
                        state_d = in_rx_byte[7] ? RD_REQ : WR_DATA;
                    end
                end
                WR_DATA: begin
                    if (in_rx_valid) begin
                        wdata_d = in_rx_byte;
                        tmr_d   = 8'h00;
                        state_d = WR_REQ;
                    end
                end
                WR_REQ: begin
                    err_event = in_rx_valid;
                    if (in_reg_ack) begin
                        addr_d  = addr + 7'd1;
                        state_d = WR_DATA;
                    end else if (tmr == TMR_LAST) begin
                        err_event = 1'b1;
                        addr_d    = addr + 7'd1;
                        state_d   = WR_DATA;
                    end else begin
                        tmr_d = tmr + 8'd1;
                    end
                end
                RD_REQ: begin
                    err_event = in_rx_valid;
                    if (in_reg_ack) begin
                        tx_byte_d  = in_reg_rdata;
                        tx_valid_d = 1'b1;
                        addr_d     = addr + 7'd1;
                        state_d    = RD_WAIT;
                    end else if (tmr == TMR_LAST) begin
                        // Timed-out read returns a recognisable filler byte.
                        err_event  = 1'b1;
                        tx_byte_d  = 8'hEE;
                        tx_valid_d = 1'b1;
                        addr_d     = addr + 7'd1;
                        state_d    = RD_WAIT;
                    end else begin
                        tmr_d = tmr + 8'd1;
                    end
                end
                RD_WAIT: begin
                    if (in_rx_valid) begin
                        tmr_d   = 8'h00;
                        state_d = RD_REQ;
                    end
                end
                default: state_d = IDLE;
            endcase
        end

        err_d = (err & ~in_err_clr) | err_event;
    end

    assign o_tx_byte   = tx_byte;
    assign o_tx_valid  = tx_valid;
    assign o_reg_addr  = addr;
    assign o_reg_wdata = wdata;
    assign o_reg_we    = (state == WR_REQ);
    assign o_reg_re    = (state == RD_REQ);
    assign o_busy      = (state != IDLE);
    assign o_err       = err;
    assign o_frame_cnt = frame_cnt;
    assign dbg_state   = state;

endmodule

// File: tb/tb_spi_cmd_ctrl.sv
// Bench for spi_cmd_ctrl: directed SPI frames checked against a flag-level
// behavioural model every cycle, a write scoreboard and literal expectations.
module tb_spi_cmd_ctrl;

    localparam int TIMEOUT = 16;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       cs_n = 1'b1;
    logic       rx_valid = 1'b0;
    logic [7:0] rx_byte = 8'h00;
    logic [7:0] reg_rdata = 8'h00;
    logic       reg_ack = 1'b0;
    logic       err_clr = 1'b0;
    logic [7:0] tx_byte;
    logic       tx_valid;
    logic [6:0] reg_addr;
    logic [7:0] reg_wdata;
    logic       reg_we;
    logic       reg_re;
    logic       busy;
    logic       err;
    logic [7:0] frame_cnt;
    logic [2:0] dbg_state;

    always #5 clk = ~clk;

    spi_cmd_ctrl #(.TIMEOUT(TIMEOUT)) dut (
        .in_clk       (clk),
        .in_rst       (rst),
        .in_cs_n      (cs_n),
        .in_rx_valid  (rx_valid),
        .in_rx_byte   (rx_byte),
        .o_tx_byte    (tx_byte),
        .o_tx_valid   (tx_valid),
        .o_reg_addr   (reg_addr),
        .o_reg_wdata  (reg_wdata),
        .o_reg_we     (reg_we),
        .o_reg_re     (reg_re),
        .in_reg_rdata (reg_rdata),
        .in_reg_ack   (reg_ack),
        .in_err_clr   (err_clr),
        .o_busy       (busy),
        .o_err        (err),
        .o_frame_cnt  (frame_cnt),
        .dbg_state    (dbg_state)
    );

    int n_checks = 0;
    int n_errs   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errs++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Behavioural model: frame/command/request flags plus a request age counter.
    bit         m_active, m_got_cmd, m_read, m_req, m_cs_prev, m_txv, m_err;
    int         m_age;
    logic [6:0] m_addr;
    logic [7:0] m_wdata, m_tx, m_fc;

    always @(posedge clk) begin : model
        bit ev;
        ev = 1'b0;
        if (rst) begin
            m_active = 0; m_got_cmd = 0; m_read = 0; m_req = 0; m_cs_prev = 0;
            m_txv = 0; m_err = 0; m_age = 0;
            m_addr = 7'h00; m_wdata = 8'h00; m_tx = 8'h00; m_fc = 8'h00;
        end else begin
            m_txv = 0;
            if (m_active && cs_n) begin
                m_active = 0;
                m_req    = 0;
                m_fc     = m_fc + 8'd1;
            end else if (!m_active) begin
                if (m_cs_prev && !cs_n) begin
                    m_active = 1; m_got_cmd = 0; m_req = 0;
                end
            end else if (!m_got_cmd) begin
                if (rx_valid) begin
                    m_got_cmd = 1;
                    m_read    = rx_byte[7];
                    m_addr    = rx_byte[6:0];
                    if (m_read) begin m_req = 1; m_age = 0; end
                end
            end else if (m_req) begin
                if (rx_valid) ev = 1;
                if (reg_ack) begin
                    m_req = 0;
                    if (m_read) begin m_tx = reg_rdata; m_txv = 1; end
                    m_addr = m_addr + 7'd1;
                end else begin
                    m_age++;
                    if (m_age == TIMEOUT) begin
                        m_req = 0; ev = 1;
                        if (m_read) begin m_tx = 8'hEE; m_txv = 1; end
                        m_addr = m_addr + 7'd1;
                    end
                end
            end else if (rx_valid) begin
                if (!m_read) m_wdata = rx_byte;
                m_req = 1; m_age = 0;
            end
            m_err     = (m_err && !err_clr) || ev;
            m_cs_prev = cs_n;
        end
    end

    bit         chk_en = 0;
    logic       snap_we;
    logic [6:0] snap_addr;
    logic [7:0] snap_wdata;

    always @(negedge clk) begin
        if (chk_en) begin
            check("cycle_outputs",
                  {busy, err, reg_we, reg_re, tx_valid, reg_addr, reg_wdata, tx_byte, frame_cnt},
                  {m_active, m_err, m_active && m_req && !m_read, m_active && m_req && m_read,
                   m_txv, m_addr, m_wdata, m_tx, m_fc});
        end
        snap_we    = reg_we;
        snap_addr  = reg_addr;
        snap_wdata = reg_wdata;
    end

    // Write scoreboard: every acknowledged write inside a frame, in order.
    logic [14:0] exp_q[$];

    always @(posedge clk) begin
        if (chk_en && !rst && snap_we && reg_ack && !cs_n) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_errs++;
                $display("FAIL write_unexpected: got %h expected none", {snap_addr, snap_wdata});
            end else begin
                check("write_txn", {snap_addr, snap_wdata}, exp_q.pop_front());
            end
        end
    end

    task automatic send_byte(input logic [7:0] b);
        rx_byte  = b;
        rx_valid = 1'b1;
        @(negedge clk);
        rx_valid = 1'b0;
    endtask

    task automatic start_frame();
        cs_n = 1'b0;
        @(negedge clk);
    endtask

    task automatic end_frame();
        cs_n = 1'b1;
        @(negedge clk);
        @(negedge clk);
    endtask

    task automatic ack_req(input int delay, input logic [7:0] rdata);
        int n;
        n = 0;
        while (!(reg_we || reg_re) && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("req_seen", reg_we || reg_re, 1'b1);
        if (reg_we || reg_re) begin
            repeat (delay) @(negedge clk);
            reg_rdata = rdata;
            reg_ack   = 1'b1;
            @(negedge clk);
            reg_ack   = 1'b0;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int cnt;
        exp_q.push_back({7'h05, 8'hA1});
        exp_q.push_back({7'h06, 8'hB2});
        exp_q.push_back({7'h7F, 8'hD1});
        exp_q.push_back({7'h00, 8'hD2});

        @(posedge clk);
        chk_en = 1;
        repeat (3) @(negedge clk);
        check("reset_outputs",
              {busy, err, reg_we, reg_re, tx_valid, reg_addr, reg_wdata, tx_byte, frame_cnt}, 36'h0);
        rst = 1'b0;
        @(negedge clk);

        // Write burst: (0x05,0xA1), (0x06,0xB2)
        start_frame();
        check("frame_busy", busy, 1'b1);
        send_byte(8'h05);
        send_byte(8'hA1);
        ack_req(2, 8'h00);
        send_byte(8'hB2);
        ack_req(2, 8'h00);
        end_frame();
        check("burst_frame_cnt", frame_cnt, 8'd1);

        // Read at 0x10 then 0x11
        start_frame();
        send_byte(8'h90);
        check("rd_latency", reg_re, 1'b1);
        check("rd_addr", reg_addr, 7'h10);
        ack_req(1, 8'h3C);
        check("rd_tx_valid", tx_valid, 1'b1);
        check("rd_tx_byte", tx_byte, 8'h3C);
        send_byte(8'h00);
        check("rd2_req", reg_re, 1'b1);
        check("rd2_addr", reg_addr, 7'h11);
        ack_req(1, 8'h55);
        end_frame();

        // Address wrap 0x7F -> 0x00
        start_frame();
        send_byte(8'h7F);
        send_byte(8'hD1);
        ack_req(2, 8'h00);
        send_byte(8'hD2);
        ack_req(2, 8'h00);
        check("wrap_addr", reg_addr, 7'h01);
        end_frame();

        // Read timeout at 0x01
        start_frame();
        send_byte(8'h81);
        cnt = 0;
        while (reg_re && cnt < 100) begin
            cnt++;
            @(negedge clk);
        end
        check("timeout_len", cnt, TIMEOUT);
        check("timeout_err", err, 1'b1);
        check("timeout_tx", tx_byte, 8'hEE);
        check("timeout_tx_valid", tx_valid, 1'b1);
        check("timeout_addr", reg_addr, 7'h02);
        err_clr = 1'b1;
        @(negedge clk);
        err_clr = 1'b0;
        check("err_cleared", err, 1'b0);
        end_frame();

        // Overrun with simultaneous err_clr, then abort by cs release
        start_frame();
        send_byte(8'h20);
        send_byte(8'h11);
        rx_byte  = 8'h99;
        rx_valid = 1'b1;
        err_clr  = 1'b1;
        @(negedge clk);
        rx_valid = 1'b0;
        err_clr  = 1'b0;
        check("overrun_err", err, 1'b1);
        check("overrun_wdata", reg_wdata, 8'h11);
        check("overrun_pending", reg_we, 1'b1);
        cs_n = 1'b1;
        @(negedge clk);
        check("abort_we", reg_we, 1'b0);
        check("abort_idle", busy, 1'b0);
        @(negedge clk);

        // Ack and cs release in the same cycle
        start_frame();
        send_byte(8'h30);
        send_byte(8'h44);
        reg_ack = 1'b1;
        cs_n    = 1'b1;
        @(negedge clk);
        reg_ack = 1'b0;
        check("cs_ack_addr", reg_addr, 7'h30);
        check("cs_ack_we", reg_we, 1'b0);
        @(negedge clk);

        // Reset mid-read, late ack ignored, no frame without fresh cs edge
        start_frame();
        send_byte(8'hC0);
        check("rst_pre_re", reg_re, 1'b1);
        rst = 1'b1;
        @(negedge clk);
        check("rst_mid_outputs",
              {busy, err, reg_we, reg_re, tx_valid, reg_addr, reg_wdata, tx_byte, frame_cnt}, 36'h0);
        rst       = 1'b0;
        reg_rdata = 8'h77;
        reg_ack   = 1'b1;
        @(negedge clk);
        reg_ack = 1'b0;
        @(negedge clk);
        check("late_ack_tx_valid", tx_valid, 1'b0);
        repeat (3) @(negedge clk);
        check("no_stale_frame", busy, 1'b0);
        cs_n = 1'b1;
        @(negedge clk);
        start_frame();
        check("fresh_frame", busy, 1'b1);
        end_frame();
        check("empty_frame_cnt", frame_cnt, 8'd1);

        // Frame counter wrap
        for (int i = 0; i < 255; i++) begin
            cs_n = 1'b0;
            @(negedge clk);
            cs_n = 1'b1;
            @(negedge clk);
        end
        check("frame_cnt_wrap", frame_cnt, 8'd0);
        cs_n = 1'b0;
        @(negedge clk);
        cs_n = 1'b1;
        @(negedge clk);
        check("frame_cnt_after_wrap", frame_cnt, 8'd1);

        check("write_q_drained", exp_q.size(), 0);
        repeat (2) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
        $finish;
    end

endmodule

// File: doc/spi_cmd_ctrl.md
SPI_CMD_CTRL -- requirements
Module: spi_cmd_ctrl

Interface
REQ-001 Parameter: TIMEOUT, 16, cycles to wait for in_reg_ack before aborting an access (range 2..255).
REQ-002 in_clk  input  1  single system clock; all logic SHALL be on its rising edge.
REQ-003 in_rst  input  1  reset, synchronous, active-high.
REQ-004 in_cs_n  input  1  SPI chip select, already synchronised to in_clk, active-low; low = frame active.
REQ-005 in_rx_valid  input  1  one-cycle strobe: byte received from SPI slave.
REQ-006 in_rx_byte  input  8  received byte, valid with in_rx_valid.
REQ-007 o_tx_byte  output  8  byte to be shifted out on the next SPI byte.
REQ-008 o_tx_valid  output  1  one-cycle strobe: o_tx_byte updated.
REQ-009 o_reg_addr  output  7  register-bank address.
REQ-010 o_reg_wdata  output  8  register-bank write data.
REQ-011 o_reg_we  output  1  write request, held until acknowledged.
REQ-012 o_reg_re  output  1  read request, held until acknowledged.
REQ-013 in_reg_rdata  input  8  read data, valid with in_reg_ack.
REQ-014 in_reg_ack  input  1  one-cycle access acknowledge.
REQ-015 in_err_clr  input  1  clears o_err.
REQ-016 o_busy  output  1  high when state is not IDLE.
REQ-017 o_err  output  1  sticky error flag.
REQ-018 o_frame_cnt  output  8  completed-frame counter.

Function
REQ-019 States SHALL be IDLE, CMD, WR_DATA, WR_REQ, RD_REQ, RD_WAIT.
REQ-020 IDLE -> CMD on in_cs_n sampled 1 then 0 (falling edge); in_rx_valid in IDLE ignored.
REQ-021 In CMD, first in_rx_valid: byte[7]=1 -> read, byte[6:0] loaded into address register; read -> RD_REQ, write -> WR_DATA.
REQ-022 WR_DATA: on in_rx_valid, o_reg_wdata <= byte, o_reg_we=1 next cycle, state WR_REQ.
REQ-023 RD_REQ: o_reg_re=1 the cycle after command byte (latency 1); state held until ack or timeout.
REQ-024 Request SHALL stay high with stable addr/wdata until in_reg_ack; deasserts the cycle after ack.
REQ-025 On write ack: address += 1 modulo 128 (0x7F wraps to 0x00), state WR_DATA.
REQ-026 On read ack at cycle a: o_tx_byte <= in_reg_rdata, o_tx_valid=1 at a+1, address += 1 mod 128, state RD_WAIT.
REQ-027 RD_WAIT: each in_rx_valid (dummy byte, content ignored) -> RD_REQ for current address.
REQ-028 Timeout: in_reg_ack absent for TIMEOUT cycles after request assert -> request deasserted, o_err set; read additionally loads o_tx_byte=0xEE with o_tx_valid pulse; state WR_DATA or RD_WAIT, address still increments.
REQ-029 Overrun: in_rx_valid while in WR_REQ or RD_REQ -> byte dropped, o_err set, pending access unaffected.
REQ-030 Frame end: in_cs_n sampled high in any non-IDLE state -> next cycle IDLE, o_reg_we/o_reg_re deasserted, pending access abandoned, o_frame_cnt += 1 (255 wraps to 0).
REQ-031 in_cs_n high and in_reg_ack in same cycle: frame end wins, no tx update, no address increment.
REQ-032 in_err_clr and an error event in same cycle: o_err stays 1.
REQ-033 in_cs_n rising with no command byte received still counts as a completed frame.

Reset
REQ-034 in_rst SHALL force, on the next in_clk edge: state IDLE, address 0x00, o_tx_byte 0x00, o_tx_valid 0, o_reg_we 0, o_reg_re 0, o_reg_wdata 0x00, o_reg_addr 0x00, o_err 0, o_busy 0, o_frame_cnt 0x00.
REQ-035 in_rst asserted mid-access SHALL drop the request that same edge; a late in_reg_ack after reset SHALL be ignored.
REQ-036 After reset release, a frame SHALL start only on a fresh in_cs_n 1->0 transition.

Verification
REQ-037 Write burst: cs low, bytes 0x05,0xA1,0xB2, ack 2 cycles after each request -> writes (0x05,0xA1),(0x06,0xB2); cs high -> o_frame_cnt=1.
REQ-038 Read: cs low, byte 0x90, ack with rdata 0x3C -> o_reg_re at addr 0x10 one cycle after cmd; o_tx_byte=0x3C, o_tx_valid pulse; dummy byte -> read of 0x11.
REQ-039 Wrap: write cmd 0x7F, two data bytes -> writes at 0x7F then 0x00.
REQ-040 Timeout: read cmd 0x81, no ack -> o_reg_re drops after 16 cycles, o_err=1, o_tx_byte=0xEE; in_err_clr -> o_err=0.
REQ-041 Overrun/abort: data byte during WR_REQ -> o_err=1, byte dropped; cs high during pending request -> o_reg_we=0 next cycle, state IDLE.
REQ-042 Reset mid-read: in_rst during RD_REQ -> all outputs at reset values next cycle; subsequent ack produces no o_tx_valid.
